// File: rtl/snn_pkg.sv
// Shared constants and address type for the SNN front end (sensor encoder,
// controller, output FIFO users).
package snn_pkg;

    localparam int NUM_SENSORS = 16;
    localparam int ADDR_W      = $clog2(NUM_SENSORS);
    localparam int FIFO_DEPTH  = 8;
    localparam int PTR_W       = $clog2(FIFO_DEPTH);
    localparam int CNT_W       = $clog2(FIFO_DEPTH + 1);

    typedef logic [ADDR_W-1:0] event_addr_t;
    typedef logic [PTR_W-1:0]  fifo_ptr_t;
    typedef logic [CNT_W-1:0]  fifo_cnt_t;

    // Depth is a power of two, so the pointer wraps by plain overflow.
    function automatic fifo_ptr_t ptr_inc(input fifo_ptr_t p);
        return p + fifo_ptr_t'(1);
    endfunction

endpackage

// File: rtl/sensor_event_encoder_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first request at or above
// ptr, wrapping around; N must be a power of two.
module rr_arbiter
    import snn_pkg::*;
#(
    parameter int N = NUM_SENSORS,
    parameter int W = ADDR_W
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    input  logic         en,
    output logic [N-1:0] grant_onehot,
    output logic [W-1:0] grant_idx,
    output logic         grant_valid
);

    // Rotating priority search starting at ptr.
    always_comb begin : search
        logic [W-1:0] idx_s;
        idx_s        = '0;
        grant_onehot = '0;
        grant_idx    = '0;
        grant_valid  = 1'b0;
        if (en) begin
            for (int i = 0; i < N; i++) begin
                idx_s = ptr + W'(i);
                if (!grant_valid && req[idx_s]) begin
                    grant_valid = 1'b1;
                    grant_idx   = idx_s;
                end else begin
                    grant_valid = grant_valid;
                end
            end
            if (grant_valid) begin
                grant_onehot[grant_idx] = 1'b1;
            end else begin
                grant_onehot = '0;
            end
        end else begin
            grant_valid = 1'b0;
        end
    end

endmodule

// File: rtl/sensor_event_encoder.sv
// Sensor spike front end: rising-edge detect, pending bitmap, round-robin
// drain into an 8-entry show-ahead address FIFO for the controller.
module sensor_event_encoder
    import snn_pkg::*;
(
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic [NUM_SENSORS-1:0] sensor_in,
    input  logic                   event_ack,
    input  logic                   overflow_clear,
    output event_addr_t            event_addr,
    output logic                   event_received,
    output logic                   overflow,
    output fifo_cnt_t              pending_count
);

    logic [NUM_SENSORS-1:0] prev_r, pending_r, edges_s, pending_next_s, grant_onehot_s;
    event_addr_t            rr_ptr_r, rr_ptr_next_s, grant_idx_s, head_next_s, event_addr_r;
    event_addr_t            mem_r [FIFO_DEPTH];
    fifo_ptr_t              wr_ptr_r, rd_ptr_r, wr_ptr_next_s, rd_ptr_next_s;
    fifo_cnt_t              count_r, count_next_s;
    logic                   grant_valid_s, arb_en_s, push_s, pop_s, coalesce_s;
    logic                   overflow_r, overflow_next_s, event_received_r;

    // Full test uses the registered count, so a same-cycle pop never frees a slot.
    assign arb_en_s = (count_r < fifo_cnt_t'(FIFO_DEPTH));

    rr_arbiter #(.N(NUM_SENSORS), .W(ADDR_W)) u_arb (
        .req          (pending_r),
        .ptr          (rr_ptr_r),
        .en           (arb_en_s),
        .grant_onehot (grant_onehot_s),
        .grant_idx    (grant_idx_s),
        .grant_valid  (grant_valid_s)
    );

    // Next-state for edges, pending bitmap, FIFO pointers and registered outputs.
    always_comb begin
        edges_s        = sensor_in & ~prev_r;
        pending_next_s = (pending_r & ~grant_onehot_s) | edges_s;
        coalesce_s     = |(edges_s & pending_r & ~grant_onehot_s);
        push_s         = grant_valid_s;
        pop_s          = event_ack && (count_r != fifo_cnt_t'(0));
        rd_ptr_next_s  = pop_s  ? ptr_inc(rd_ptr_r) : rd_ptr_r;
        wr_ptr_next_s  = push_s ? ptr_inc(wr_ptr_r) : wr_ptr_r;
        rr_ptr_next_s  = push_s ? (grant_idx_s + event_addr_t'(1)) : rr_ptr_r;
        case ({push_s, pop_s})
            2'b10:   count_next_s = count_r + fifo_cnt_t'(1);
            2'b01:   count_next_s = count_r - fifo_cnt_t'(1);
            default: count_next_s = count_r;
        endcase
        // Head after this edge may be the entry being written right now.
        if (count_next_s == fifo_cnt_t'(0)) begin
            head_next_s = '0;
        end else if (push_s && (rd_ptr_next_s == wr_ptr_r)) begin
            head_next_s = grant_idx_s;
        end else begin
            head_next_s = mem_r[rd_ptr_next_s];
        end
        if (coalesce_s) begin
            overflow_next_s = 1'b1;
        end else if (overflow_clear) begin
            overflow_next_s = 1'b0;
        end else begin
            overflow_next_s = overflow_r;
        end
    end

    // Control state and registered outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            prev_r           <= '0;
            pending_r        <= '0;
            rr_ptr_r         <= '0;
            wr_ptr_r         <= '0;
            rd_ptr_r         <= '0;
            count_r          <= '0;
            overflow_r       <= 1'b0;
            event_received_r <= 1'b0;
            event_addr_r     <= '0;
        end else begin
            prev_r           <= sensor_in;
            pending_r        <= pending_next_s;
            rr_ptr_r         <= rr_ptr_next_s;
            wr_ptr_r         <= wr_ptr_next_s;
            rd_ptr_r         <= rd_ptr_next_s;
            count_r          <= count_next_s;
            overflow_r       <= overflow_next_s;
            event_received_r <= (count_next_s != fifo_cnt_t'(0));
            event_addr_r     <= head_next_s;
        end
    end

    // FIFO storage.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else if (push_s) begin
            mem_r[wr_ptr_r] <= grant_idx_s;
        end else begin
            mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
        end
    end

    assign event_addr     = event_addr_r;
    assign event_received = event_received_r;
    assign overflow       = overflow_r;
    assign pending_count  = count_r;

endmodule

// File: tb/tb_sensor_event_encoder.sv
// Randomised plus directed bench for sensor_event_encoder against a
// queue-based behavioural model of the edge/pending/arbiter/FIFO rules.
module tb_sensor_event_encoder;

    logic        clock = 1'b0;
    logic        reset_n = 1'b1;
    logic [15:0] sensor_in = 16'h0000;
    logic        event_ack = 1'b0;
    logic        overflow_clear = 1'b0;
    logic [3:0]  event_addr;
    logic        event_received;
    logic        overflow;
    logic [3:0]  pending_count;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    bit m_prev [16];
    bit m_pend [16];
    int m_rr;
    int m_q [$];
    bit m_ovf;

    sensor_event_encoder dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .sensor_in      (sensor_in),
        .event_ack      (event_ack),
        .overflow_clear (overflow_clear),
        .event_addr     (event_addr),
        .event_received (event_received),
        .overflow       (overflow),
        .pending_count  (pending_count)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            m_prev[i] = 1'b0;
            m_pend[i] = 1'b0;
        end
        m_rr  = 0;
        m_q   = {};
        m_ovf = 1'b0;
    endtask

    task automatic model_step(input logic [15:0] s, input bit ack, input bit clr);
        int g;
        int tmp;
        bit coal;
        bit edge_i;
        g    = -1;
        coal = 1'b0;
        if (m_q.size() < 8) begin
            for (int k = 0; k < 16; k++) begin
                if (g < 0 && m_pend[(m_rr + k) % 16]) g = (m_rr + k) % 16;
            end
        end
        if (ack && m_q.size() > 0) tmp = m_q.pop_front();
        for (int i = 0; i < 16; i++) begin
            edge_i = s[i] && !m_prev[i];
            if (edge_i && m_pend[i] && i != g) coal = 1'b1;
            m_pend[i] = (m_pend[i] && i != g) || edge_i;
            m_prev[i] = s[i];
        end
        if (g >= 0) begin
            m_q.push_back(g);
            m_rr = (g + 1) % 16;
        end
        if (coal) m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
    endtask

    task automatic check_all(input string pfx);
        check_eq({pfx, "_recv"},  int'(event_received), (m_q.size() > 0) ? 1 : 0);
        check_eq({pfx, "_addr"},  int'(event_addr),     (m_q.size() > 0) ? m_q[0] : 0);
        check_eq({pfx, "_count"}, int'(pending_count),  m_q.size());
        check_eq({pfx, "_ovf"},   int'(overflow),       int'(m_ovf));
    endtask

    task automatic tick(input string pfx, input logic [15:0] s, input bit ack, input bit clr);
        sensor_in      = s;
        event_ack      = ack;
        overflow_clear = clr;
        @(posedge clock);
        model_step(s, ack, clr);
        #1;
        check_all(pfx);
    endtask

    // Asynchronous reset: outputs must clear before any clock edge.
    task automatic do_reset(input logic [15:0] hold);
        sensor_in      = hold;
        event_ack      = 1'b0;
        overflow_clear = 1'b0;
        reset_n        = 1'b0;
        #1;
        check_eq("rst_recv",  int'(event_received), 0);
        check_eq("rst_addr",  int'(event_addr),     0);
        check_eq("rst_count", int'(pending_count),  0);
        check_eq("rst_ovf",   int'(overflow),       0);
        model_reset();
        @(posedge clock);
        #2;
        reset_n = 1'b1;
    endtask

    task automatic drain(input string pfx, input int n);
        for (int i = 0; i < n; i++) tick(pfx, 16'h0000, 1'b1, 1'b0);
    endtask

    initial begin
        #2;
        do_reset(16'h0000);
        tick("idle", 16'h0000, 1'b0, 1'b0);

        // Single event: two-cycle latency, one ack retires it
        tick("single", 16'h0020, 1'b0, 1'b0);
        tick("single", 16'h0000, 1'b0, 1'b0);
        check_eq("single_addr5", int'(event_addr), 5);
        tick("single_ack", 16'h0000, 1'b1, 1'b0);
        check_eq("single_empty", int'(event_received), 0);

        // Round robin from ptr 0, then wrap from ptr 15
        do_reset(16'h0000);
        tick("rr", 16'h4208, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) tick("rr", 16'h0000, 1'b0, 1'b0);
        check_eq("rr_head3", int'(event_addr), 3);
        drain("rr_drain", 3);
        tick("rrw", 16'h8004, 1'b0, 1'b0);
        tick("rrw", 16'h0000, 1'b0, 1'b0);
        tick("rrw", 16'h0000, 1'b0, 1'b0);
        check_eq("rr_wrap_head15", int'(event_addr), 15);
        drain("rrw_drain", 3);

        // Full backpressure, then coalescing on bit 12 while it waits
        do_reset(16'h0000);
        for (int i = 0; i < 10; i++) tick("full", 16'hFFFF, 1'b0, 1'b0);
        check_eq("full_count8", int'(pending_count), 8);
        tick("coal", 16'h0000, 1'b0, 1'b0);
        tick("coal", 16'h1000, 1'b0, 1'b0);
        check_eq("coal_ovf", int'(overflow), 1);
        tick("coal", 16'h0000, 1'b0, 1'b0);
        tick("coal", 16'h1000, 1'b0, 1'b0);
        tick("coal_clr", 16'h0000, 1'b0, 1'b1);
        check_eq("coal_cleared", int'(overflow), 0);
        tick("coal_both", 16'h1000, 1'b0, 1'b1);
        check_eq("coal_set_wins", int'(overflow), 1);
        drain("full_drain", 18);

        // Empty ack, then simultaneous push and pop at count 3
        do_reset(16'h0000);
        tick("eack", 16'h0000, 1'b1, 1'b0);
        tick("pp", 16'h0007, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) tick("pp", 16'h0000, 1'b0, 1'b0);
        check_eq("pp_count3", int'(pending_count), 3);
        tick("pp", 16'h0100, 1'b0, 1'b0);
        tick("pp_both", 16'h0000, 1'b1, 1'b0);
        check_eq("pp_count_hold", int'(pending_count), 3);
        drain("pp_drain", 4);

        // Mid-stream reset with a sensor held high across release
        do_reset(16'h0000);
        for (int i = 0; i < 6; i++) tick("mid", 16'hFFFF, 1'b0, 1'b0);
        check_eq("mid_count5", int'(pending_count), 5);
        do_reset(16'h0080);
        for (int i = 0; i < 4; i++) tick("held", 16'h0080, 1'b0, 1'b0);
        check_eq("held_one", int'(pending_count), 1);
        drain("held_drain", 2);

        // Random traffic
        for (int i = 0; i < 500; i++) begin
            logic [15:0] s;
            s = 16'($urandom) & 16'($urandom);
            tick("rand", s, ($urandom_range(0, 2) != 0), ($urandom_range(0, 7) == 0));
        end
        drain("rand_drain", 24);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/sensor_event_encoder.md
# sensor_event_encoder

- Upstream stage of the SNN core; turns 16 sensor spike lines into a queue of 4-bit address events for the controller.
- Per-sensor rising-edge detection feeds a pending register. A round-robin arbiter drains it into an 8-entry address FIFO.
- The FIFO head drives the controller's `event_addr` / `event_received` pair, and the controller pops it with `event_ack` once the event is processed.

## Interface
- `NUM_SENSORS`, 16: number of sensor inputs. Power of two.
- `ADDR_W`, `$clog2(NUM_SENSORS)` = 4: width of an event address.
- `FIFO_DEPTH`, 8: address FIFO entries. Power of two.
- `clock` input 1: single clock; all state on the rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `sensor_in` input `NUM_SENSORS`: spike lines, already synchronous to `clock`. An event is a 0→1 transition.
- `event_ack` input 1: controller pops the FIFO head. Ignored when empty.
- `overflow_clear` input 1: clears `overflow`.
- `event_addr` output `ADDR_W`: FIFO head address (show-ahead). Value is 0 when empty.
- `event_received` output 1: FIFO not empty.
- `overflow` output 1: sticky flag, set when an event was coalesced (lost).
- `pending_count` output `$clog2(FIFO_DEPTH+1)`: current FIFO occupancy.

## Operation
- **Edge detect**
  - `edges = sensor_in & ~prev`, combinational.
  - `prev <= sensor_in` every cycle.
- **Pending register** (`NUM_SENSORS` bits)
  - `pending_next = (pending & ~grant_onehot) | edges`.
  - An edge on a bit already pending and not granted this cycle is coalesced: the bit stays 1 and `overflow` sets.
  - An edge on the bit granted this cycle re-arms it. This is not an overflow.
- **Arbiter**
  - Runs when `pending != 0` and the FIFO count is below `FIFO_DEPTH`.
  - Grants the first pending bit at or after `rr_ptr`, searching upward with wrap.
  - Grants at most one sensor per cycle.
  - On grant: push the sensor index into the FIFO and set `rr_ptr <= grant_idx + 1` (mod `NUM_SENSORS`).
  - `rr_ptr` does not change when there is no grant.
- **FIFO**
  - Circular buffer with read/write pointers and a count.
  - A pop occurs when `event_ack` is asserted and count > 0.
  - Full test uses the registered count: when the FIFO is full, no grant happens even if a pop occurs in the same cycle. Nothing is lost; events wait in `pending`.
  - A push and a pop in the same cycle leave the count unchanged.
- **Overflow flag**
  - Set by coalescing.
  - `overflow_clear` clears it.
  - Set wins over clear in the same cycle.

## Timing
- **Reset values:**
  - `prev`, `pending`, `rr_ptr` and FIFO pointers are all 0; count is 0.
  - Outputs: `event_received`=0, `event_addr`=0, `overflow`=0, `pending_count`=0.
- **Reset release:** `prev` resets to 0, so a sensor held high through reset release produces exactly one event.
- **Latency:** `sensor_in` rises before edge E0 → pending set at E0 → FIFO write at E1 → `event_received`=1 and `event_addr` valid after E1. Total: 2 cycles from input change to visible event when the path is idle.
- **Throughput:** one push and one pop per cycle.
- **Pop timing:** `event_ack` sampled at edge E retires the head. The next entry, if any, is visible after E.
- **Mid-operation reset:** asserting `reset_n` low discards all pending and queued events immediately (asynchronous).

## Structure
- Shared package `snn_pkg` holds:
  - constants `NUM_SENSORS` and `ADDR_W`;
  - `typedef logic [ADDR_W-1:0] event_addr_t`.
- The same address type is used by `controller` and `out_fifo` users.
- Sub-module `rr_arbiter`:
  - inputs: `req[NUM_SENSORS]`, `ptr`, `en`;
  - outputs: `grant_onehot`, `grant_idx`, `grant_valid`;
  - purely combinational, reusable.
- FIFO storage and pointers stay inline.

## Test plan
- **Single event:** pulse `sensor_in[5]` for 1 cycle at E0 → `event_received`=1 and `event_addr`=5 after E1. `event_ack` one cycle → `event_received`=0.
- **Round-robin:** rise bits 3, 9 and 14 simultaneously with `rr_ptr`=0 → FIFO order 3, 9, 14, with `rr_ptr`=15 afterwards. Then rise bits 2 and 15 → order 15, 2 (wrap).
- **Full backpressure:** no acks; rise all 16 bits → `pending_count` saturates at 8 with addresses 0–7. Ack 8 times → remaining 8–15 delivered in order. `overflow` stays 0.
- **Coalescing:** FIFO full; toggle `sensor_in[12]` 0→1→0→1 while bit 12 pending → `overflow`=1 and only one address 12 delivered. `overflow_clear` → 0. Clear and a new coalescing edge in the same cycle → stays 1.
- **Empty ack and push/pop:** `event_ack` while empty → no pointer change, count stays 0. With count 3, push and ack in the same cycle → count stays 3 and order is preserved.
- **Reset:** mid-stream with count 5 and pending nonzero, pulse `reset_n` low → all outputs 0 immediately. Sensor held high across release → exactly one event for it.
